// File: rtl/sp_ram_rr_arbiter.sv
// Two-requester round-robin arbiter that sequences read/write commands onto a
// single-port RAM (synchronous write, asynchronous read) with registered outputs.
module sp_ram_rr_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  req0_in,
  input  logic                  we0_in,
  input  logic [ADDR_WIDTH-1:0] addr0_in,
  input  logic [DATA_WIDTH-1:0] wdata0_in,
  output logic                  ack0_out,
  input  logic                  req1_in,
  input  logic                  we1_in,
  input  logic [ADDR_WIDTH-1:0] addr1_in,
  input  logic [DATA_WIDTH-1:0] wdata1_in,
  output logic                  ack1_out,
  output logic [DATA_WIDTH-1:0] rdata_out,
  output logic                  busy_out,
  output logic                  ram_write_en_out,
  output logic [ADDR_WIDTH-1:0] ram_address_out,
  output logic [DATA_WIDTH-1:0] ram_wdata_out,
  input  logic [DATA_WIDTH-1:0] ram_rdata_in
);

  typedef enum logic [1:0] {IDLE, GRANT, ACK} state_t;

  state_t                r_state,    w_state_nxt;
  logic                  r_gnt_id,   w_gnt_id_nxt;
  logic                  r_last_gnt, w_last_gnt_nxt;
  logic                  r_ack0,     w_ack0_nxt;
  logic                  r_ack1,     w_ack1_nxt;
  logic                  r_we,       w_we_nxt;
  logic [ADDR_WIDTH-1:0] r_addr,     w_addr_nxt;
  logic [DATA_WIDTH-1:0] r_wdata,    w_wdata_nxt;
  logic [DATA_WIDTH-1:0] r_rdata,    w_rdata_nxt;

  logic w_cand0, w_cand1, w_win;

  // The requester currently being acked is masked so the other one gets its turn.
  assign w_cand0 = req0_in && !((r_state == ACK) && (r_gnt_id == 1'b0));
  assign w_cand1 = req1_in && !((r_state == ACK) && (r_gnt_id == 1'b1));
  assign w_win   = (w_cand0 && w_cand1) ? ~r_last_gnt : w_cand1;

  always_comb begin
    // NOTE: every next-state value gets a default first, so no path can infer a latch.
    w_state_nxt    = r_state;
    w_gnt_id_nxt   = r_gnt_id;
    w_last_gnt_nxt = r_last_gnt;
    w_ack0_nxt     = 1'b0;
    w_ack1_nxt     = 1'b0;
    w_we_nxt       = r_we;
    w_addr_nxt     = r_addr;
    w_wdata_nxt    = r_wdata;
    w_rdata_nxt    = r_rdata;

    case (r_state)
      GRANT: begin
        w_rdata_nxt = ram_rdata_in;
        w_ack0_nxt  = ~r_gnt_id;
        w_ack1_nxt  = r_gnt_id;
        w_we_nxt    = 1'b0;
        w_state_nxt = ACK;
      end
      default: begin
        if (w_cand0 || w_cand1) begin
          w_state_nxt    = GRANT;
          w_gnt_id_nxt   = w_win;
          w_last_gnt_nxt = w_win;
          w_addr_nxt     = w_win ? addr1_in  : addr0_in;
          w_wdata_nxt    = w_win ? wdata1_in : wdata0_in;
          w_we_nxt       = w_win ? we1_in    : we0_in;
        end else begin
          w_state_nxt = IDLE;
          w_we_nxt    = 1'b0;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state    <= IDLE;
      r_gnt_id   <= 1'b0;
      r_last_gnt <= 1'b1;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt_id   <= w_gnt_id_nxt;
      r_last_gnt <= w_last_gnt_nxt;
      r_ack0     <= w_ack0_nxt;
      r_ack1     <= w_ack1_nxt;
      r_we       <= w_we_nxt;
      r_addr     <= w_addr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_rdata    <= w_rdata_nxt;
    end
  end

  assign ack0_out         = r_ack0;
  assign ack1_out         = r_ack1;
  assign rdata_out        = r_rdata;
  assign busy_out         = (r_state != IDLE);
  assign ram_write_en_out = r_we;
  assign ram_address_out  = r_addr;
  assign ram_wdata_out    = r_wdata;

endmodule

// File: tb/tb_sp_ram_rr_arbiter.sv
// Bench for sp_ram_rr_arbiter: directed scenarios plus random traffic against a
// grant-history model and a shadow memory; a behavioural RAM sits on the RAM port.
module tb_sp_ram_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ram_clr = 1'b0;
  logic       req [2];
  logic       we [2];
  logic [7:0] addr [2];
  logic [7:0] wdata [2];
  logic       ack0, ack1, busy, ram_we;
  logic [7:0] ram_addr, ram_wdata, ram_rdata, rdata;

  always #5 clk = ~clk;

  sp_ram_rr_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk_in(clk), .rst_n_in(rst_n),
    .req0_in(req[0]), .we0_in(we[0]), .addr0_in(addr[0]), .wdata0_in(wdata[0]), .ack0_out(ack0),
    .req1_in(req[1]), .we1_in(we[1]), .addr1_in(addr[1]), .wdata1_in(wdata[1]), .ack1_out(ack1),
    .rdata_out(rdata), .busy_out(busy),
    .ram_write_en_out(ram_we), .ram_address_out(ram_addr), .ram_wdata_out(ram_wdata),
    .ram_rdata_in(ram_rdata)
  );

  // Behavioural 256x8 RAM: synchronous write, asynchronous read.
  logic [7:0] ram [256];
  always @(posedge clk) begin
    if (ram_clr) for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
    else if (ram_we) ram[ram_addr] <= ram_wdata;
  end
  assign ram_rdata = ram[ram_addr];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // Model: a grant at edge n puts the command on the RAM during n..n+1, acks
  // during n+1..n+2, and the acked requester sits out the arbitration at n+2.
  typedef struct {
    logic       v;
    logic       id;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } grant_t;

  grant_t     g_prev, g_prev2;
  logic       m_last;
  logic [7:0] m_mem [256];
  logic [7:0] exp_addr, exp_wdata, exp_rdata;
  logic       exp_ack [2];
  int         ack_log [$];

  task automatic model_reset();
    g_prev     = '{default: '0};
    g_prev2    = '{default: '0};
    m_last     = 1'b1;
    exp_addr   = 8'h00;
    exp_wdata  = 8'h00;
    exp_rdata  = 8'h00;
    exp_ack[0] = 1'b0;
    exp_ack[1] = 1'b0;
  endtask

  task automatic step();
    grant_t g_now;
    logic   c0, c1, win;
    @(posedge clk);
    g_now = '{default: '0};
    if (!g_prev.v) begin
      c0 = req[0] && !(g_prev2.v && !g_prev2.id);
      c1 = req[1] && !(g_prev2.v &&  g_prev2.id);
      if (c0 || c1) begin
        win         = (c0 && c1) ? !m_last : c1;
        m_last      = win;
        g_now.v     = 1'b1;
        g_now.id    = win;
        g_now.we    = we[win];
        g_now.addr  = addr[win];
        g_now.wdata = wdata[win];
        exp_addr    = addr[win];
        exp_wdata   = wdata[win];
      end
    end
    if (g_prev.v) begin
      exp_rdata = m_mem[g_prev.addr];
      if (g_prev.we) m_mem[g_prev.addr] = g_prev.wdata;
      ack_log.push_back(int'(g_prev.id));
    end
    exp_ack[0] = g_prev.v && !g_prev.id;
    exp_ack[1] = g_prev.v &&  g_prev.id;
    @(negedge clk);
    check("ram_we",    32'(ram_we),    32'(g_now.v && g_now.we));
    check("ram_addr",  32'(ram_addr),  32'(exp_addr));
    check("ram_wdata", 32'(ram_wdata), 32'(exp_wdata));
    check("ack0",      32'(ack0),      32'(exp_ack[0]));
    check("ack1",      32'(ack1),      32'(exp_ack[1]));
    check("busy",      32'(busy),      32'(g_now.v || g_prev.v));
    check("rdata",     32'(rdata),     32'(exp_rdata));
    g_prev2 = g_prev;
    g_prev  = g_now;
  endtask

  task automatic do_reset(input logic clear_ram);
    rst_n   = 1'b0;
    ram_clr = clear_ram;
    for (int k = 0; k < 2; k++) begin
      req[k] = 1'b0; we[k] = 1'b0; addr[k] = 8'h00; wdata[k] = 8'h00;
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_ack0",  32'(ack0),      32'd0);
    check("rst_ack1",  32'(ack1),      32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_we",    32'(ram_we),    32'd0);
    check("rst_addr",  32'(ram_addr),  32'd0);
    check("rst_wdata", 32'(ram_wdata), 32'd0);
    check("rst_rdata", 32'(rdata),     32'd0);
    @(negedge clk);
    ram_clr = 1'b0;
    rst_n   = 1'b1;
    if (clear_ram) for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
    model_reset();
  endtask

  task automatic xact(input int k, input logic w, input logic [7:0] a, input logic [7:0] d);
    logic done = 1'b0;
    req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d;
    for (int i = 0; i < 8 && !done; i++) begin
      step();
      done = exp_ack[k];
    end
    req[k] = 1'b0;
  endtask

  task automatic new_cmd(input int k);
    req[k]   = 1'b1;
    we[k]    = 1'($urandom_range(0, 1));
    addr[k]  = 8'($urandom_range(0, 15)) ^ (($urandom_range(0, 1) != 0) ? 8'hF0 : 8'h00);
    wdata[k] = 8'($urandom_range(0, 255));
  endtask

  initial begin
    model_reset();
    do_reset(1'b1);

    // Single write from requester 0.
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 8'h10; wdata[0] = 8'hA5;
    step();
    check("w1_we",   32'(ram_we),   32'd1);
    check("w1_addr", 32'(ram_addr), 32'h10);
    step();
    check("w1_ack0", 32'(ack0),   32'd1);
    check("w1_we_0", 32'(ram_we), 32'd0);
    req[0] = 1'b0;
    step();
    check("w1_idle", 32'(busy), 32'd0);

    // Read it back through requester 1.
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 8'h10; wdata[1] = 8'h00;
    step();
    step();
    check("r1_ack1",  32'(ack1),  32'd1);
    check("r1_rdata", 32'(rdata), 32'hA5);
    req[1] = 1'b0;
    step();

    // Simultaneous requests after reset: requester 0 first, then 1 back-to-back.
    do_reset(1'b1);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 8'h01; wdata[0] = 8'h11;
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 8'h02; wdata[1] = 8'h22;
    step();
    step();
    check("tie_ack0", 32'(ack0), 32'd1);
    req[0] = 1'b0;
    step();
    step();
    check("tie_ack1", 32'(ack1), 32'd1);
    req[1] = 1'b0;
    step();
    check("tie_ram1", 32'(ram[1]), 32'h11);
    check("tie_ram2", 32'(ram[2]), 32'h22);

    // Continuous dual requests: strict alternation with no idle cycles.
    do_reset(1'b1);
    ack_log.delete();
    new_cmd(0);
    new_cmd(1);
    for (int c = 0; c < 16; c++) begin
      step();
      check("rr_busy", 32'(busy), 32'd1);
      for (int k = 0; k < 2; k++) if (exp_ack[k]) new_cmd(k);
    end
    check("rr_count", 32'(ack_log.size()), 32'd8);
    for (int i = 0; i < 8 && i < ack_log.size(); i++) check("rr_order", 32'(ack_log[i]), 32'(i % 2));
    req[0] = 1'b0; req[1] = 1'b0;
    step();
    step();

    // Read-before-write at the top address.
    xact(0, 1'b1, 8'hFF, 8'h55);
    xact(0, 1'b1, 8'hFF, 8'h66);
    check("rbw_ff", 32'(rdata), 32'h55);
    xact(1, 1'b0, 8'hFF, 8'h00);
    check("rd_ff", 32'(rdata), 32'h66);

    // Reset asserted in the middle of a GRANT cycle.
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 8'h20; wdata[0] = 8'h77;
    step();
    check("mg_we_pre", 32'(ram_we), 32'd1);
    #1 rst_n = 1'b0;
    req[0] = 1'b0;
    #1;
    check("mg_we",   32'(ram_we), 32'd0);
    check("mg_ack0", 32'(ack0),   32'd0);
    check("mg_busy", 32'(busy),   32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step();
    check("mg_idle", 32'(busy), 32'd0);
    xact(0, 1'b0, 8'h20, 8'h00);
    check("mg_nowrite", 32'(rdata), 32'h00);
    xact(1, 1'b1, 8'h30, 8'h99);
    xact(0, 1'b0, 8'h30, 8'h00);
    check("mg_fresh", 32'(rdata), 32'h99);

    // Random traffic from both requesters.
    for (int c = 0; c < 1500; c++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        if (exp_ack[k]) begin
          if ($urandom_range(0, 3) != 0) new_cmd(k);
          else req[k] = 1'b0;
        end else if (!req[k] && $urandom_range(0, 2) == 0) begin
          new_cmd(k);
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
